audio_sigma_delta: RTL

AUDIO_SIGMA_DELTA -- requirements
Module: audio_sigma_delta

---
 rtl/zx48_audio_pkg.sv | 13 +
 rtl/audio_dsm_ch.sv | 49 ++++
 rtl/audio_sigma_delta.sv | 100 ++++++++++
 3 files changed

// File: rtl/zx48_audio_pkg.sv
// zx48_audio_pkg: shared fader state type, gain scaling and dither LFSR constants for audio_sigma_delta
package zx48_audio_pkg;
  typedef enum logic [1:0] {PLAY, FADE_OUT, MUTED, FADE_IN} fade_state_t;
  localparam int GAIN_MAX = 16;
  localparam int GAIN_SHIFT = 4;
  typedef logic [$clog2(GAIN_MAX+1)-1:0] gain_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction
endpackage

// File: rtl/audio_dsm_ch.sv
// audio_dsm_ch: one channel - sample latch, gain scaler, first-order delta-sigma modulator
// Ports: clock/reset (async, active-high), sample_ce latches x, gain 0..16, dac = 1-bit density stream.
// With AUDIO_DITHER_EN defined, dith selects a +1/-1 nudge added before carry extraction.
module audio_dsm_ch
  import zx48_audio_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sample_ce,
  input  logic [DW-1:0] x,
  input  gain_t         gain,
`ifdef AUDIO_DITHER_EN
  input  logic          dith,
`endif
  output logic          dac
);
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  logic [DW-1:0] xin, y, y_next;
  logic [DW:0] acc, acc_next;
  logic signed [DW+5:0] diff, prod;
`ifdef AUDIO_DITHER_EN
  logic [DW+2:0] s;
`endif
  always_comb begin
    diff = $signed({6'b0, xin}) - $signed({6'b0, MID});
    prod = diff * $signed((DW+6)'(gain));
    y_next = MID + DW'(prod >>> GAIN_SHIFT);
`ifdef AUDIO_DITHER_EN
    s = (DW+3)'(acc[DW-1:0]) + (DW+3)'(y) + (dith ? (DW+3)'(1) : '1);
    acc_next = s[DW+2] ? '0 : s[DW+1] ? '1 : s[DW:0];
`else
    acc_next = {1'b0, acc[DW-1:0]} + {1'b0, y};
`endif
  end
  // The carry out of the previous update is the registered 1-bit output.
  assign dac = acc[DW];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      xin <= MID;
      y   <= MID;
      acc <= '0;
    end else begin
      xin <= sample_ce ? x : xin;
      y   <= y_next;
      acc <= acc_next;
    end
endmodule

// File: rtl/audio_sigma_delta.sv
// audio_sigma_delta: stereo 1-bit delta-sigma audio DAC with a shared soft-mute fader
// Ports: clock, reset (async, active-high), sample_ce latches laudio/raudio, mute requests a soft mute,
// dac_l/dac_r are registered density streams, muted is high while the fader sits in MUTED.
// Optional feature: define AUDIO_DITHER_EN to add a 16-bit LFSR +/-1 dither to both modulators.
module audio_sigma_delta
  import zx48_audio_pkg::*;
#(
  parameter int DW       = 10,
  parameter int RAMP_DIV = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sample_ce,
  input  logic          mute,
  input  logic [DW-1:0] laudio,
  input  logic [DW-1:0] raudio,
  output logic          dac_l,
  output logic          dac_r,
  output logic          muted
);
  localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  logic [CW-1:0] ramp;
  logic tick;
  fade_state_t state, state_next;
  gain_t gain, gain_next;
  assign tick = ramp == CW'(RAMP_DIV-1);
  assign muted = state == MUTED;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ramp  <= '0;
      state <= MUTED;
      gain  <= '0;
    end else begin
      ramp  <= tick ? '0 : ramp + 1'b1;
      state <= state_next;
      gain  <= gain_next;
    end
  // A direction change or entry into a fade never steps gain on the same clock,
  // so a coincident tick cannot double-step.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    case (state)
      PLAY: begin
        gain_next  = gain_t'(GAIN_MAX);
        state_next = mute ? FADE_OUT : PLAY;
      end
      FADE_OUT:
        if (!mute) state_next = FADE_IN;
        else if (gain == '0) state_next = MUTED;
        else if (tick) begin
          gain_next  = gain - 1'b1;
          state_next = gain == gain_t'(1) ? MUTED : FADE_OUT;
        end
      MUTED: begin
        gain_next  = '0;
        state_next = mute ? MUTED : FADE_IN;
      end
      FADE_IN:
        if (mute) state_next = FADE_OUT;
        else if (gain == gain_t'(GAIN_MAX)) state_next = PLAY;
        else if (tick) begin
          gain_next  = gain + 1'b1;
          state_next = gain == gain_t'(GAIN_MAX-1) ? PLAY : FADE_IN;
        end
      default: begin
        state_next = MUTED;
        gain_next  = '0;
      end
    endcase
  end
`ifdef AUDIO_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or posedge reset)
    if (reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr_fb(lfsr)};
`endif
  audio_dsm_ch #(.DW(DW)) u_l (
    .clock(clock),
    .reset(reset),
    .sample_ce(sample_ce),
    .x(laudio),
    .gain(gain),
`ifdef AUDIO_DITHER_EN
    .dith(lfsr[0]),
`endif
    .dac(dac_l)
  );
  audio_dsm_ch #(.DW(DW)) u_r (
    .clock(clock),
    .reset(reset),
    .sample_ce(sample_ce),
    .x(raudio),
    .gain(gain),
`ifdef AUDIO_DITHER_EN
    .dith(lfsr[8]),
`endif
    .dac(dac_r)
  );
endmodule
